// File: rtl/mux_arbiter_pkg.sv
// Shared encodings for the datapath mux arbiter: FSM states, mux select codes
// and small index helpers.
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  localparam logic [2:0] MUXOP_NONE = 3'b111;
  localparam logic [2:0] MUXOP_IN0  = 3'b000;
  localparam logic [2:0] MUXOP_IN1  = 3'b001;
  localparam logic [2:0] MUXOP_IN2  = 3'b010;
  localparam logic [2:0] MUXOP_IN3  = 3'b011;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [2:0] idx_to_muxop(input logic [1:0] idx);
    logic [2:0] op;
    case (idx)
      2'd0:    op = MUXOP_IN0;
      2'd1:    op = MUXOP_IN1;
      2'd2:    op = MUXOP_IN2;
      default: op = MUXOP_IN3;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick4.sv
// Combinational round-robin winner select over four requesters; the search
// starts at last+1 and wraps, so the previous owner has lowest priority.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    any = |req;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) win = idx;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer for the shared 32-bit 4:1 datapath mux:
// one owner at a time, released on done, abandon or hold-time limit.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no owner; pick a round-robin winner when any req is high
// ST_GRANT   | owner holds the mux; count hold cycles, watch done/req
// ST_RELEASE | one-cycle turnaround bubble, mux select parked at 3'b111
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       MUXop,
  output logic             busy,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_n;
  logic [1:0] owner, owner_n;
  logic [1:0] last, last_n;
  logic [7:0] hold_cnt, hold_n;
  logic [N_REQ-1:0] gnt_n;
  logic [2:0] muxop_n;
  logic       busy_n;
  logic       timeout_n;

  logic [1:0] pick_win;
  logic       pick_any;
  logic       done_own;
  logic       req_own;
  logic       hold_end;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .win  (pick_win),
    .any  (pick_any)
  );

  assign done_own = done[owner];
  assign req_own  = req[owner];
  assign hold_end = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    last_n    = last;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    muxop_n   = MUXop;
    busy_n    = busy;
    timeout_n = 1'b0;

    case (state)
      ST_IDLE: begin
        gnt_n   = '0;
        muxop_n = MUXOP_NONE;
        busy_n  = 1'b0;
        if (pick_any) begin
          state_n = ST_GRANT;
          owner_n = pick_win;
          hold_n  = 8'd0;
          gnt_n   = idx_to_onehot(pick_win);
          muxop_n = idx_to_muxop(pick_win);
          busy_n  = 1'b1;
        end
      end

      ST_GRANT: begin
        hold_n = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
        if (done_own || !req_own || hold_end) begin
          state_n   = ST_RELEASE;
          last_n    = owner;
          gnt_n     = '0;
          muxop_n   = MUXOP_NONE;
          busy_n    = 1'b0;
          // done and abandon both take precedence over a coincident hold limit
          timeout_n = hold_end && !done_own && req_own;
        end
      end

      ST_RELEASE: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        muxop_n = MUXOP_NONE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        muxop_n = MUXOP_NONE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      owner    <= 2'd0;
      last     <= 2'd3;
      hold_cnt <= 8'd0;
      gnt      <= '0;
      MUXop    <= MUXOP_NONE;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      last     <= last_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      MUXop    <= muxop_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
    end
  end

endmodule
